uart_tx_feeder: RTL and testbench

Upstream stage for the UART transmitter: accepts bytes from the host side into an on-chip FIFO and drains them one at a time into the transmitter's `start`/`data_in`/`busy` handshake. Lets the host burst up to DEPTH bytes without polling `busy`. Sits between the system write path and the transmitter instance in the UART top level, sharing its clock and reset.

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 76 +++++++
 rtl/uart_tx_feeder.sv | 137 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the transmit-feeder FSM states.
// The receiver-side buffer imports this package as well.
package uart_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      TXF_IDLE = 2'd0,
      TXF_ARM  = 2'd1,
      TXF_SEND = 2'd2
   } txf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count flags.
// The head entry is visible combinationally on head_data whenever the FIFO is non-empty.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int  DATA_W = BYTE_W,
   parameter int  DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, empty_q;
   logic              push_ok, pop_ok;

   // Flags come from the registered count, so a push while full is refused even if a pop happens too.
   assign push_ok = push && !full_q;
   assign pop_ok  = pop && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == (ADDR_W+1)'(DEPTH));
         empty_q  <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign full      = full_q;
   assign empty     = empty_q;
   assign count     = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Host-side byte buffer that drains one byte at a time into the UART transmitter's
// start/busy handshake, flagging dropped writes and starts the transmitter never acknowledged.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int  DEPTH       = 16,
   parameter int  ARM_TIMEOUT = 16,
   localparam int ADDR_W      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [BYTE_W-1:0] wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              tx_err,
   input  logic              clr_flags,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [BYTE_W-1:0] tx_data,
   output logic              byte_sent
);

   localparam int               TMO_W    = $clog2(ARM_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARM_TIMEOUT - 1);

   txf_state_e        state_q, state_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              tx_start_q, tx_start_d;
   logic              byte_sent_q, byte_sent_d;
   logic [BYTE_W-1:0] tx_data_q, tx_data_d;
   logic              overflow_q, overflow_d;
   logic              tx_err_q, tx_err_d;
   logic              pop;
   logic              err_set;
   logic              fifo_full, fifo_empty;
   logic [BYTE_W-1:0] head_data;

   sync_fifo #(
      .DATA_W (BYTE_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (pop),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count)
   );

   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      tx_start_d  = 1'b0;
      byte_sent_d = 1'b0;
      tx_data_d   = tx_data_q;
      pop         = 1'b0;
      err_set     = 1'b0;
      unique case (state_q)
         TXF_IDLE: begin
            if (!fifo_empty && !tx_busy) begin
               pop        = 1'b1;
               tx_data_d  = head_data;
               tx_start_d = 1'b1;
               tmo_d      = '0;
               state_d    = TXF_ARM;
            end
         end
         TXF_ARM: begin
            // A start the transmitter never acknowledges is abandoned; the byte is lost.
            if (tx_busy) begin
               state_d = TXF_SEND;
            end else if (tmo_q == TMO_LAST) begin
               err_set = 1'b1;
               state_d = TXF_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         TXF_SEND: begin
            if (!tx_busy) begin
               byte_sent_d = 1'b1;
               state_d     = TXF_IDLE;
            end
         end
         default: state_d = TXF_IDLE;
      endcase

      // Set events take priority over a simultaneous clear.
      overflow_d = overflow_q;
      if (wr_en && fifo_full) begin
         overflow_d = 1'b1;
      end else if (clr_flags) begin
         overflow_d = 1'b0;
      end
      tx_err_d = tx_err_q;
      if (err_set) begin
         tx_err_d = 1'b1;
      end else if (clr_flags) begin
         tx_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= TXF_IDLE;
         tmo_q       <= '0;
         tx_start_q  <= 1'b0;
         byte_sent_q <= 1'b0;
         tx_data_q   <= '0;
         overflow_q  <= 1'b0;
         tx_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         tx_start_q  <= tx_start_d;
         byte_sent_q <= byte_sent_d;
         tx_data_q   <= tx_data_d;
         overflow_q  <= overflow_d;
         tx_err_q    <= tx_err_d;
      end
   end

   assign full      = fifo_full;
   assign empty     = fifo_empty;
   assign overflow  = overflow_q;
   assign tx_err    = tx_err_q;
   assign tx_start  = tx_start_q;
   assign tx_data   = tx_data_q;
   assign byte_sent = byte_sent_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a simple transmitter model driving tx_busy.
module tb_uart_tx_feeder;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int FRAME  = 10;

   logic              clk = 1'b0;
   logic              rst, wr_en, clr_flags, tx_busy;
   logic [7:0]        wr_data, tx_data;
   logic              full, empty, overflow, tx_err, tx_start, byte_sent;
   logic [ADDR_W:0]   count;

   logic              force_busy, model_on, busy_q, prev_start;
   int                hold_q;
   int                n_checks = 0, n_errors = 0;
   int                cyc = 0, start_cnt = 0, sent_cnt = 0, last_start_cyc = 0, wr_cyc = 0;
   logic [7:0]        sb [$];

   uart_tx_feeder #(.DEPTH(DEPTH), .ARM_TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .tx_err    (tx_err),
      .clr_flags (clr_flags),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .byte_sent (byte_sent)
   );

   always #5 clk = ~clk;

   assign tx_busy = force_busy | busy_q;

   // Transmitter model: busy rises the cycle after start and stays high FRAME cycles.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         busy_q <= 1'b0;
         hold_q <= 0;
      end else if (model_on && tx_start) begin
         busy_q <= 1'b1;
         hold_q <= FRAME - 1;
      end else if (busy_q) begin
         if (hold_q == 0) busy_q <= 1'b0;
         else hold_q <= hold_q - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (tx_start) begin
            chk("start_one_cycle", 32'(prev_start), 32'd0);
            start_cnt++;
            last_start_cyc = cyc;
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) chk("tx_data_order", 32'(tx_data), 32'(sb.pop_front()));
         end
         if (byte_sent) sent_cnt++;
      end
      prev_start = tx_start;
   end

   task automatic wr(input logic [7:0] b, input bit accept);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = b;
      wr_cyc  = cyc;
      if (accept) sb.push_back(b);
   endtask

   task automatic wr_stop();
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_sent(input int n, input int budget, input string tag);
      int k = 0;
      while (sent_cnt < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(sent_cnt), 32'(n));
   endtask

   task automatic wait_starts(input int n, input int budget, input string tag);
      int k = 0;
      while (start_cnt < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(start_cnt), 32'(n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, sbase, s1, e1, k;
      rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr_flags = 1'b0;
      force_busy = 1'b0; model_on = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_tx_err", 32'(tx_err), 32'd0);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_byte_sent", 32'(byte_sent), 32'd0);
      rst = 1'b0;

      // Single byte through an idle transmitter
      wr(8'hA5, 1'b1);
      wr_stop();
      wait_sent(1, 60, "t1_sent");
      chk("t1_latency", 32'(last_start_cyc - wr_cyc), 32'd2);
      repeat (5) @(negedge clk);
      chk("t1_sent_once", 32'(sent_cnt), 32'd1);
      chk("t1_empty", 32'(empty), 32'd1);

      // Fill while stalled, overflow, flag clear priority
      force_busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) wr(8'(i), 1'b1);
      wr_stop();
      chk("t2_full", 32'(full), 32'd1);
      chk("t2_count", 32'(count), 32'd16);
      wr(8'h10, 1'b0);
      wr_stop();
      chk("t2_overflow", 32'(overflow), 32'd1);
      chk("t2_count_after_drop", 32'(count), 32'd16);
      @(negedge clk); clr_flags = 1'b1;
      @(negedge clk); clr_flags = 1'b0;
      chk("t2_ovf_cleared", 32'(overflow), 32'd0);
      @(negedge clk); wr_en = 1'b1; wr_data = 8'h11; clr_flags = 1'b1;
      @(negedge clk); wr_en = 1'b0; clr_flags = 1'b0;
      chk("t6_set_beats_clear", 32'(overflow), 32'd1);
      @(negedge clk); clr_flags = 1'b1;
      @(negedge clk); clr_flags = 1'b0;
      base = sent_cnt; sbase = start_cnt;
      force_busy = 1'b0;
      wait_sent(base + 16, 16 * (FRAME + 6) + 20, "t2_all_sent");
      repeat (5) @(negedge clk);
      chk("t2_starts", 32'(start_cnt - sbase), 32'd16);
      chk("t2_sb_drained", 32'(sb.size()), 32'd0);
      chk("t2_empty", 32'(empty), 32'd1);

      // Transmitter never acknowledges: timeout, next byte launched, clear
      model_on = 1'b0;
      base = sent_cnt; sbase = start_cnt;
      wr(8'h3C, 1'b1);
      wr(8'h3D, 1'b1);
      wr_stop();
      wait_starts(sbase + 1, 10, "t3_first_start");
      s1 = last_start_cyc;
      k = 0;
      while (!tx_err && k < 40) begin @(negedge clk); k++; end
      e1 = cyc;
      chk("t3_tx_err", 32'(tx_err), 32'd1);
      chk("t3_err_timing", 32'(e1 - s1), 32'd16);
      wait_starts(sbase + 2, 10, "t3_second_start");
      chk("t3_relaunch_gap", 32'(last_start_cyc - s1), 32'd17);
      repeat (25) @(negedge clk);
      chk("t3_no_sent", 32'(sent_cnt), 32'(base));
      @(negedge clk); clr_flags = 1'b1;
      @(negedge clk); clr_flags = 1'b0;
      chk("t3_err_cleared", 32'(tx_err), 32'd0);
      chk("t3_empty", 32'(empty), 32'd1);
      model_on = 1'b1;

      // Simultaneous push and pop at count 5
      force_busy = 1'b1;
      base = sent_cnt;
      for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i), 1'b1);
      @(negedge clk);
      chk("t4_pre_count", 32'(count), 32'd5);
      force_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h55; sb.push_back(8'h55);
      @(negedge clk);
      wr_en = 1'b0;
      chk("t4_count_held", 32'(count), 32'd5);
      wait_sent(base + 6, 6 * (FRAME + 6) + 20, "t4_all_sent");
      chk("t4_sb_drained", 32'(sb.size()), 32'd0);

      // Reset while a frame is in SEND with 3 bytes queued
      force_busy = 1'b1;
      for (int i = 0; i < 4; i++) wr(8'h70 + 8'(i), 1'b1);
      @(negedge clk);
      wr_en = 1'b0; force_busy = 1'b0;
      k = 0;
      while (!busy_q && k < 10) begin @(negedge clk); k++; end
      chk("t5_busy_seen", 32'(busy_q), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      base = sent_cnt; sbase = start_cnt;
      @(negedge clk);
      chk("t5_empty", 32'(empty), 32'd1);
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_tx_start", 32'(tx_start), 32'd0);
      chk("t5_tx_data", 32'(tx_data), 32'd0);
      chk("t5_byte_sent", 32'(byte_sent), 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("t5_no_sent", 32'(sent_cnt), 32'(base));
      chk("t5_no_start", 32'(start_cnt), 32'(sbase));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
